// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU register file and its scoreboard.
// Register addresses are always 5 bits wide. RV32E builds use only 16 registers,
// so the upper half of the address space is treated as "null", like x0.
package cpu_pkg;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO    = 5'd0;
   localparam int        REG_COUNT_I = 32;
   localparam int        REG_COUNT_E = 16;

   // True for x0 and for any address beyond the implemented register count.
   function automatic logic is_null_reg(input reg_addr_t addr, input int count);
      return (addr == REG_ZERO) || (int'(addr) >= count);
   endfunction

endpackage

// File: rtl/cpu_reg_file_sb_if.sv
// Decode/writeback bus of the register file with integrated scoreboard.
// The master modport is the pipeline side (decode + writeback).
// The slave modport is the register file.
// XLEN and READ_PORTS must match the parameters of the attached cpu_reg_file_sb.
interface cpu_reg_file_sb_if #(
   parameter int XLEN       = 32,
   parameter int READ_PORTS = 2
);
   import cpu_pkg::*;

   logic [READ_PORTS-1:0]      rd_en;
   logic [READ_PORTS*5-1:0]    rd_addr;
   logic [READ_PORTS*XLEN-1:0] rd_data;
   logic [READ_PORTS-1:0]      rd_busy;
   logic                       stall;
   logic                       rsv_en;
   reg_addr_t                  rsv_addr;
   logic                       rsv_conflict;
   logic                       wr_en;
   reg_addr_t                  wr_addr;
   logic [XLEN-1:0]            wr_data;

   modport master (
      output rd_en, rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_busy, stall, rsv_conflict
   );

   modport slave (
      input  rd_en, rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_busy, stall, rsv_conflict
   );

endinterface

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Decode sets a bit on issue; writeback clears it.
// A reservation that hits an already-busy register is a WAW conflict and is dropped.
// Optional feature: CPU_REG_FILE_BYPASS_EN (a same-cycle write to the reserved
// register counts as having cleared its busy bit).
module cpu_scoreboard
   import cpu_pkg::*;
#(
   parameter int REG_COUNT = REG_COUNT_I
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rsv_en,
   input  reg_addr_t            rsv_addr,
   input  logic                 wr_en,
   input  reg_addr_t            wr_addr,
   output logic [REG_COUNT-1:0] busy,
   output logic                 rsv_conflict
);

   localparam int AW = $clog2(REG_COUNT);

   logic [REG_COUNT-1:0] busy_reg;
   logic [REG_COUNT-1:0] rsv_hit;
   logic [REG_COUNT-1:0] wr_hit;
   logic                 rsv_valid;
   logic                 wr_valid;
   logic                 rsv_accept;

   // Qualify requests against null registers and detect WAW on pre-edge busy state
   always_comb begin
      rsv_valid = rsv_en && !is_null_reg(rsv_addr, REG_COUNT);
      wr_valid  = wr_en  && !is_null_reg(wr_addr,  REG_COUNT);
`ifdef CPU_REG_FILE_BYPASS_EN
      rsv_conflict = rsv_valid && busy_reg[rsv_addr[AW-1:0]]
                     && !(wr_valid && (wr_addr == rsv_addr));
`else
      rsv_conflict = rsv_valid && busy_reg[rsv_addr[AW-1:0]];
`endif
      rsv_accept = rsv_valid && !rsv_conflict;
   end

   // One-hot decode of the accepted reservation and the writeback target
   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_decode
      assign rsv_hit[gi] = rsv_accept && (rsv_addr == reg_addr_t'(gi));
      assign wr_hit[gi]  = wr_valid   && (wr_addr  == reg_addr_t'(gi));
   end

   // Writeback clears busy; an accepted reservation sets it and wins on a tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= (busy_reg & ~wr_hit) | rsv_hit;
      end
   end

   assign busy = busy_reg;

endmodule

// File: rtl/cpu_reg_file_sb.sv
// General-purpose register file with configurable read ports and an integrated
// pending-write scoreboard, used by decode to stall on RAW and WAW hazards.
// Reads are combinational. Without forwarding, a write is visible the cycle after wr_en.
// Optional feature: CPU_REG_FILE_BYPASS_EN (forward writeback data to
// same-cycle reads of the written register).
module cpu_reg_file_sb
   import cpu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_COUNT  = REG_COUNT_I,
   parameter int READ_PORTS = 2
) (
   input logic              clk,
   input logic              rst_n,
   cpu_reg_file_sb_if.slave bus
);

   localparam int AW = $clog2(REG_COUNT);

   logic [XLEN-1:0]       regs_reg [REG_COUNT];
   logic [REG_COUNT-1:0]  busy;
   logic [READ_PORTS-1:0] rd_busy_w;
   logic                  rsv_conflict_w;
   logic                  wr_valid;

   assign wr_valid = bus.wr_en && !is_null_reg(bus.wr_addr, REG_COUNT);

   // Architectural register array; x0 is never written, so it stays zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wr_valid) begin
         regs_reg[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      end
   end

   cpu_scoreboard #(
      .REG_COUNT (REG_COUNT)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .rsv_en       (bus.rsv_en),
      .rsv_addr     (bus.rsv_addr),
      .wr_en        (bus.wr_en),
      .wr_addr      (bus.wr_addr),
      .busy         (busy),
      .rsv_conflict (rsv_conflict_w)
   );

   // Per-port read mux: null registers read as zero and are never busy
   for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read
      reg_addr_t       addr;
      logic            addr_null;
      logic [XLEN-1:0] data_arr;
      logic            busy_arr;

      assign addr      = bus.rd_addr[5*gi +: 5];
      assign addr_null = is_null_reg(addr, REG_COUNT);
      assign data_arr  = addr_null ? '0   : regs_reg[addr[AW-1:0]];
      assign busy_arr  = addr_null ? 1'b0 : busy[addr[AW-1:0]];

`ifdef CPU_REG_FILE_BYPASS_EN
      logic fwd;
      assign fwd = wr_valid && (bus.wr_addr == addr);
      assign bus.rd_data[XLEN*gi +: XLEN] = fwd ? bus.wr_data : data_arr;
      assign rd_busy_w[gi]                = busy_arr && !fwd;
`else
      assign bus.rd_data[XLEN*gi +: XLEN] = data_arr;
      assign rd_busy_w[gi]                = busy_arr;
`endif
   end

   assign bus.rd_busy      = rd_busy_w;
   assign bus.rsv_conflict = rsv_conflict_w;
   assign bus.stall        = (|(bus.rd_en & rd_busy_w)) | rsv_conflict_w;

endmodule

// File: tb/tb_cpu_reg_file_sb.sv
// Scoreboard-style bench for cpu_reg_file_sb (RV32E, 4 read ports).
// Each step drives inputs after a posedge and queues the expected outputs.
// At the following negedge the queue is popped and compared against the DUT.
module tb_cpu_reg_file_sb;
   import cpu_pkg::*;

   localparam int XLEN = 32;
   localparam int RC   = REG_COUNT_E;
   localparam int RP   = 4;

   localparam int S_BUSY  = 4;
   localparam int S_STALL = 8;
   localparam int S_CONF  = 9;

`ifdef CPU_REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   cpu_reg_file_sb_if #(.XLEN(XLEN), .READ_PORTS(RP)) bus ();

   cpu_reg_file_sb #(
      .XLEN       (XLEN),
      .REG_COUNT  (RC),
      .READ_PORTS (RP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // sel 0..3: rd_data[port], 4..7: rd_busy[port], 8: stall, 9: rsv_conflict
   function automatic logic [31:0] observe(input int sel);
      if (sel < S_BUSY)        return bus.rd_data[XLEN*sel +: XLEN];
      else if (sel < S_STALL)  return {31'd0, bus.rd_busy[sel-S_BUSY]};
      else if (sel == S_STALL) return {31'd0, bus.stall};
      else                     return {31'd0, bus.rsv_conflict};
   endfunction

   task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic en, input logic [4:0] a);
      bus.rd_en[p]         = en;
      bus.rd_addr[5*p +: 5] = a;
   endtask

   task automatic clear_rd();
      bus.rd_en   = '0;
      bus.rd_addr = '0;
   endtask

   task automatic ctrl(input logic re, input logic [4:0] ra,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
      bus.rsv_en   = re;
      bus.rsv_addr = ra;
      bus.wr_en    = we;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
   endtask

   initial begin
      clear_rd();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      for (int p = 0; p < RP; p++) begin
         set_rd(p, 1'b0, 5'(p + 1));
         expect_out($sformatf("rst_data%0d", p), p, 32'h0);
         expect_out($sformatf("rst_busy%0d", p), S_BUSY + p, 32'h0);
      end
      expect_out("rst_stall", S_STALL, 32'h0);
      expect_out("rst_conf", S_CONF, 32'h0);
      step();

      // Asynchronous reset mid-operation
      clear_rd();
      ctrl(1'b1, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      set_rd(0, 1'b1, 5'd5);
      set_rd(1, 1'b0, 5'd6);
      expect_out("pre_rst_x5", 0, 32'hDEADBEEF);
      expect_out("pre_rst_busy6", S_BUSY + 1, 32'h1);
      expect_out("pre_rst_stall", S_STALL, 32'h0);
      step();
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      expect_out("async_rst_x5", 0, 32'h0);
      expect_out("async_rst_busy6", S_BUSY + 1, 32'h0);
      drain();

      // Null registers: x0 and x20 (beyond RV32E), plus top register x15
      clear_rd();
      ctrl(1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678);
      step();
      ctrl(1'b0, 5'd0, 1'b1, 5'd20, 32'hFFFFFFFF);
      step();
      ctrl(1'b1, 5'd0, 1'b1, 5'd15, 32'h0F0F0F0F);
      set_rd(0, 1'b1, 5'd0);
      set_rd(1, 1'b1, 5'd20);
      set_rd(2, 1'b1, 5'd4);
      set_rd(3, 1'b0, 5'd15);
      expect_out("null_x0_data", 0, 32'h0);
      expect_out("null_x20_data", 1, 32'h0);
      expect_out("alias_x4_data", 2, 32'h0);
      expect_out("null_x0_busy", S_BUSY + 0, 32'h0);
      expect_out("null_x20_busy", S_BUSY + 1, 32'h0);
      expect_out("null_rsv_stall", S_STALL, 32'h0);
      expect_out("null_rsv_conf", S_CONF, 32'h0);
      step();
      ctrl(1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
      expect_out("x15_data", 3, 32'h0F0F0F0F);
      expect_out("null_x20_rsv_conf", S_CONF, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      expect_out("after_null_rsv_busy0", S_BUSY + 0, 32'h0);
      expect_out("after_null_rsv_busy1", S_BUSY + 1, 32'h0);
      expect_out("after_null_rsv_stall", S_STALL, 32'h0);
      step();

      // RAW hazard on x3
      clear_rd();
      ctrl(1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
      set_rd(0, 1'b1, 5'd3);
      expect_out("raw_c0_busy", S_BUSY, 32'h0);
      expect_out("raw_c0_stall", S_STALL, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         expect_out($sformatf("raw_c%0d_busy", c), S_BUSY, 32'h1);
         expect_out($sformatf("raw_c%0d_stall", c), S_STALL, 32'h1);
         expect_out($sformatf("raw_c%0d_data", c), 0, 32'h0);
         step();
      end
      ctrl(1'b0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5);
      expect_out("raw_c4_data", 0, BYP ? 32'hA5A5A5A5 : 32'h0);
      expect_out("raw_c4_busy", S_BUSY, BYP ? 32'h0 : 32'h1);
      expect_out("raw_c4_stall", S_STALL, BYP ? 32'h0 : 32'h1);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      expect_out("raw_c5_data", 0, 32'hA5A5A5A5);
      expect_out("raw_c5_busy", S_BUSY, 32'h0);
      expect_out("raw_c5_stall", S_STALL, 32'h0);
      step();

      // WAW on x7
      clear_rd();
      ctrl(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
      expect_out("waw_first_conf", S_CONF, 32'h0);
      expect_out("waw_first_stall", S_STALL, 32'h0);
      step();
      expect_out("waw_second_conf", S_CONF, 32'h1);
      expect_out("waw_second_stall", S_STALL, 32'h1);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      set_rd(1, 1'b0, 5'd7);
      expect_out("waw_busy_kept", S_BUSY + 1, 32'h1);
      expect_out("waw_noen_stall", S_STALL, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b1, 5'd7, 32'h00000077);
      step();
      ctrl(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
      expect_out("waw_retry_conf", S_CONF, 32'h0);
      expect_out("waw_cleared_busy", S_BUSY + 1, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      expect_out("waw_retry_busy", S_BUSY + 1, 32'h1);
      expect_out("waw_x7_data", 1, 32'h00000077);
      step();
      ctrl(1'b0, 5'd0, 1'b1, 5'd7, 32'h0);
      step();

      // Simultaneous reserve + write
      clear_rd();
      set_rd(0, 1'b0, 5'd9);
      ctrl(1'b1, 5'd9, 1'b1, 5'd9, 32'h00000011);
      expect_out("sim_free_conf", S_CONF, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      expect_out("sim_x9_data", 0, 32'h00000011);
      expect_out("sim_x9_busy", S_BUSY, 32'h1);
      step();
      ctrl(1'b1, 5'd9, 1'b1, 5'd9, 32'h00000022);
      expect_out("sim_busy_conf", S_CONF, BYP ? 32'h0 : 32'h1);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      expect_out("sim_x9_data2", 0, 32'h00000022);
      expect_out("sim_x9_busy2", S_BUSY, BYP ? 32'h1 : 32'h0);
      step();
      ctrl(1'b1, 5'd11, 1'b1, 5'd12, 32'h00000012);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      set_rd(1, 1'b0, 5'd11);
      set_rd(2, 1'b0, 5'd12);
      expect_out("diff_x11_busy", S_BUSY + 1, 32'h1);
      expect_out("diff_x12_data", 2, 32'h00000012);
      expect_out("diff_x12_busy", S_BUSY + 2, 32'h0);
      step();

      // All four ports on x10
      clear_rd();
      ctrl(1'b0, 5'd0, 1'b1, 5'd10, 32'h55AA55AA);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      for (int p = 0; p < RP; p++) begin
         set_rd(p, p[0] == 1'b0, 5'd10);
         expect_out($sformatf("multi_data%0d", p), p, 32'h55AA55AA);
         expect_out($sformatf("multi_idle_busy%0d", p), S_BUSY + p, 32'h0);
      end
      expect_out("multi_idle_stall", S_STALL, 32'h0);
      step();
      bus.rd_en = '0;
      ctrl(1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
      step();
      ctrl(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      for (int p = 0; p < RP; p++) begin
         expect_out($sformatf("multi_busy%0d", p), S_BUSY + p, 32'h1);
      end
      expect_out("multi_noen_stall", S_STALL, 32'h0);
      step();
      set_rd(2, 1'b1, 5'd10);
      expect_out("multi_en2_stall", S_STALL, 32'h1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
